// File: rtl/fp_lp_pkg.sv
// Shared definitions for the LP multiplier normalize-and-pack stage.
package fp_lp_pkg;

    localparam int unsigned DEF_EXP_WIDTH = 8;
    localparam int unsigned DEF_MAN_WIDTH = 23;
    localparam int          DEF_BIAS      = 127;

    // Operand classes; subnormals are folded into CLS_ZERO.
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_t;

    // Canonical quiet NaN is {0, all-ones, 1, zeros}; infinity uses an all-ones exponent.
    localparam logic QNAN_SIGN    = 1'b0;
    localparam logic QNAN_MAN_MSB = 1'b1;
    localparam logic INF_EXP_BIT  = 1'b1;

    // Bit positions within flags = {invalid, overflow, underflow}.
    localparam int unsigned FLAG_INVALID   = 2;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 0;

endpackage

// File: rtl/fp_lp_classify.sv
// Combinational per-operand classifier (zero / normal / inf / nan).
import fp_lp_pkg::*;

module fp_lp_classify #(
    parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int unsigned MAN_WIDTH = DEF_MAN_WIDTH
) (
    input  logic [EXP_WIDTH-1:0] exp_field,
    input  logic [MAN_WIDTH-1:0] man_field,
    output fp_class_t            cls
);

    // Decode the class from exponent/mantissa fields; exp==0 flushes to zero.
    always_comb begin
        cls = CLS_NORM;
        if (exp_field == '0) begin
            cls = CLS_ZERO;
        end else if (exp_field == '1) begin
            cls = (man_field == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_lp_pack.sv
// Two-stage valid/ready normalize-and-pack stage behind the LP mantissa multiplier.
import fp_lp_pkg::*;

module fp_lp_pack #(
    parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int unsigned MAN_WIDTH = DEF_MAN_WIDTH,
    parameter int          BIAS      = DEF_BIAS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   op_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   op_b,
    input  logic [MAN_WIDTH-1:0]           lp_mantissa,
    input  logic [1:0]                     lp_shift,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   result,
    output logic [2:0]                     flags
);

    localparam int unsigned W  = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int unsigned SW = EXP_WIDTH + 2;
    localparam logic signed [SW-1:0] EXP_MAX = SW'((2 ** EXP_WIDTH) - 1);

    fp_class_t             cls_a;
    fp_class_t             cls_b;
    logic [1:0]            eff_shift;
    logic [SW-1:0]         sum_in;

    logic                  s1_valid;
    logic                  s1_sign;
    fp_class_t             s1_cls_a;
    fp_class_t             s1_cls_b;
    logic signed [SW-1:0]  s1_exp_sum;
    logic [MAN_WIDTH-1:0]  s1_man;

    logic                  s2_valid;
    logic [W-1:0]          s2_result;
    logic [2:0]            s2_flags;

    logic                  s1_load;
    logic                  s2_load;
    logic [W-1:0]          pack_result;
    logic [2:0]            pack_flags;
    logic                  any_nan;
    logic                  any_inf;
    logic                  any_zero;
    logic                  inf_zero;
    logic                  exp_ovf;
    logic                  exp_udf;

    fp_lp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cls_a (
        .exp_field (op_a[MAN_WIDTH +: EXP_WIDTH]),
        .man_field (op_a[MAN_WIDTH-1:0]),
        .cls       (cls_a)
    );

    fp_lp_classify #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) u_cls_b (
        .exp_field (op_b[MAN_WIDTH +: EXP_WIDTH]),
        .man_field (op_b[MAN_WIDTH-1:0]),
        .cls       (cls_b)
    );

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign flags     = s2_flags;

    // Biased exponent sum; the LP integer part 2'b00 is promoted to 2'b01, and
    // only an integer part >= 2 bumps the exponent by one.
    always_comb begin
        eff_shift = (lp_shift == 2'b00) ? 2'b01 : lp_shift;
        sum_in    = {2'b00, op_a[MAN_WIDTH +: EXP_WIDTH]}
                  + {2'b00, op_b[MAN_WIDTH +: EXP_WIDTH]}
                  - SW'(BIAS)
                  + SW'(eff_shift >> 1);
    end

    // S1: capture sign, operand classes, exponent sum and mantissa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_cls_a   <= CLS_ZERO;
            s1_cls_b   <= CLS_ZERO;
            s1_exp_sum <= '0;
            s1_man     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= op_a[W-1] ^ op_b[W-1];
                s1_cls_a   <= cls_a;
                s1_cls_b   <= cls_b;
                s1_exp_sum <= sum_in;
                s1_man     <= lp_mantissa;
            end
        end
    end

    // Pack S1 into an IEEE-format word in strict special-case priority order.
    always_comb begin
        any_nan  = (s1_cls_a == CLS_NAN)  || (s1_cls_b == CLS_NAN);
        any_inf  = (s1_cls_a == CLS_INF)  || (s1_cls_b == CLS_INF);
        any_zero = (s1_cls_a == CLS_ZERO) || (s1_cls_b == CLS_ZERO);
        inf_zero = ((s1_cls_a == CLS_INF) && (s1_cls_b == CLS_ZERO))
                || ((s1_cls_b == CLS_INF) && (s1_cls_a == CLS_ZERO));
        exp_ovf  = s1_exp_sum >= EXP_MAX;
        exp_udf  = s1_exp_sum[SW-1] || (s1_exp_sum == '0);

        pack_result = '0;
        pack_flags  = '0;
        if (any_nan || inf_zero) begin
            pack_result = {QNAN_SIGN, {EXP_WIDTH{INF_EXP_BIT}}, QNAN_MAN_MSB, {(MAN_WIDTH-1){1'b0}}};
            pack_flags[FLAG_INVALID] = inf_zero;
        end else if (any_inf) begin
            pack_result = {s1_sign, {EXP_WIDTH{INF_EXP_BIT}}, {MAN_WIDTH{1'b0}}};
        end else if (any_zero) begin
            pack_result = {s1_sign, {(W-1){1'b0}}};
        end else if (exp_ovf) begin
            pack_result = {s1_sign, {EXP_WIDTH{INF_EXP_BIT}}, {MAN_WIDTH{1'b0}}};
            pack_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (exp_udf) begin
            pack_result = {s1_sign, {(W-1){1'b0}}};
            pack_flags[FLAG_UNDERFLOW] = 1'b1;
        end else begin
            pack_result = {s1_sign, s1_exp_sum[EXP_WIDTH-1:0], s1_man};
        end
    end

    // S2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= pack_result;
                s2_flags  <= pack_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_lp_pack.sv
// Scoreboard bench for fp_lp_pack: directed spec vectors, backpressure, reset, random traffic.
module tb_fp_lp_pack;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [22:0] lp_mantissa = '0;
    logic [1:0]  lp_shift = 2'b01;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [2:0]  flags;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   accepted = 0;
    int   ready_mode = 1;
    bit   bp_done = 1'b0;

    fp_lp_pack #(.EXP_WIDTH(8), .MAN_WIDTH(23), .BIAS(127)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .lp_mantissa (lp_mantissa),
        .lp_shift    (lp_shift),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference model: IEEE field arithmetic with plain integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [22:0] man, input logic [1:0] sh);
        int   ea, eb, e;
        logic s;
        bit   za, zb, ia, ib, na, nb;
        exp_t r;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 0);
        ib = (eb == 255) && (b[22:0] == 0);
        na = (ea == 255) && (a[22:0] != 0);
        nb = (eb == 255) && (b[22:0] != 0);
        if (na || nb || (ia && zb) || (ib && za)) begin
            r.res = 32'h7FC0_0000;
            r.flg = {((ia && zb) || (ib && za)), 2'b00};
        end else if (ia || ib) begin
            r.res = {s, 31'h7F80_0000};
            r.flg = 3'b000;
        end else if (za || zb) begin
            r.res = {s, 31'h0};
            r.flg = 3'b000;
        end else begin
            e = ea + eb - 127 + ((sh >= 2'd2) ? 1 : 0);
            if (e >= 255) begin
                r.res = {s, 31'h7F80_0000};
                r.flg = 3'b010;
            end else if (e <= 0) begin
                r.res = {s, 31'h0};
                r.flg = 3'b001;
            end else begin
                r.res = {s, e[7:0], man};
                r.flg = 3'b000;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        int          r;
        r = $urandom_range(0, 9);
        m = 23'($urandom);
        case (r)
            0:       e = 8'h00;
            1: begin
                e = 8'hFF;
                if ($urandom_range(0, 1) == 0) m = '0;
            end
            2, 3:    e = 8'($urandom_range(120, 134));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Drives one beat starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                             input logic [22:0] man, input logic [1:0] sh, input exp_t e);
        op_a        = a;
        op_b        = b;
        lp_mantissa = man;
        lp_shift    = sh;
        in_valid    = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                accepted++;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    // Directed beat with an unstalled pipeline: out_valid must appear exactly 2 cycles later.
    task automatic send_lat(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [22:0] man, input logic [1:0] sh,
                            input logic [31:0] res, input logic [2:0] flg);
        exp_t e;
        e.res = res;
        e.flg = flg;
        send_beat(a, b, man, sh, e);
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({name, "_lat2"}, 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Single driver of out_ready: forced low, forced high, or random.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: compare every delivered beat against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("flags", 64'(flags), 64'(e.flg));
                end
            end
        end
    end

    initial begin : main
        logic [31:0] snap_res;
        logic [2:0]  snap_flg;
        int          acc0;
        logic [31:0] a, b;
        logic [22:0] m;
        logic [1:0]  sh;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors
        send_lat("nominal",   32'h3FC00000, 32'h3FC00000, 23'h100000, 2'b10, 32'h40100000, 3'b000);
        send_lat("inf_x_0",   32'h7F800000, 32'h00000000, 23'h0,      2'b01, 32'h7FC00000, 3'b100);
        send_lat("ninf_x_2",  32'hFF800000, 32'h40000000, 23'h0,      2'b01, 32'hFF800000, 3'b000);
        send_lat("ovf",       32'h7F000000, 32'h40000000, 23'h0,      2'b01, 32'h7F800000, 3'b010);
        send_lat("udf",       32'h00800000, 32'h3F000000, 23'h0,      2'b01, 32'h00000000, 3'b001);
        send_lat("subnorm",   32'h00000001, 32'h3F800000, 23'h0,      2'b01, 32'h00000000, 3'b000);
        send_lat("max_norm",  32'h7F000000, 32'h3F800000, 23'h123456, 2'b01, 32'h7F123456, 3'b000);
        send_lat("min_norm",  32'h00800000, 32'h3F800000, 23'h000005, 2'b01, 32'h00800005, 3'b000);
        send_lat("shift00",   32'h3F800000, 32'h3F800000, 23'h000007, 2'b00, 32'h3F800007, 3'b000);
        send_lat("nan_x_0",   32'h7F800001, 32'h00000000, 23'h0,      2'b01, 32'h7FC00000, 3'b000);
        send_lat("neg_one",   32'hBF800000, 32'h3F800000, 23'h0,      2'b01, 32'hBF800000, 3'b000);
        send_lat("neg_zero",  32'h80000000, 32'h3F800000, 23'h0,      2'b01, 32'h80000000, 3'b000);

        // Backpressure: 4 back-to-back beats against a stalled consumer
        ready_mode = 0;
        acc0 = accepted;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    a  = 32'h3F800000 + 32'(i << 23);
                    b  = 32'h40000000;
                    m  = 23'(32'h11111 * (i + 1));
                    sh = 2'b10;
                    send_beat(a, b, m, sh, model(a, b, m, sh));
                end
                in_valid = 1'b0;
                bp_done = 1'b1;
            end
        join_none
        repeat (3) @(negedge clk);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        snap_res = result;
        snap_flg = flags;
        repeat (4) begin
            @(negedge clk);
            check("bp_hold_res", 64'(result), 64'(snap_res));
            check("bp_hold_flg", 64'(flags), 64'(snap_flg));
        end
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_accepts", 64'(accepted - acc0), 64'd2);
        @(posedge clk);
        #1;
        ready_mode = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_no_gap", 64'(out_valid), 64'd1);
        end
        for (int t = 0; t < 100 && !bp_done; t++) @(posedge clk);
        check("bp_done", 64'(bp_done), 64'd1);
        @(posedge clk);
        #1;
        check("bp_drained", 64'(sb_q.size()), 64'd0);

        // Reset with both stages full
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        send_beat(32'h3FC00000, 32'h3FC00000, 23'h1, 2'b10, model(32'h3FC00000, 32'h3FC00000, 23'h1, 2'b10));
        send_beat(32'h40000000, 32'h40000000, 23'h2, 2'b01, model(32'h40000000, 32'h40000000, 23'h2, 2'b01));
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_full_valid", 64'(out_valid), 64'd1);
        check("mid_full_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_flags", 64'(flags), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        sb_q.delete();
        ready_mode = 1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        send_lat("post_rst", 32'h3FC00000, 32'h3FC00000, 23'h100000, 2'b10, 32'h40100000, 3'b000);

        // Random traffic with random backpressure
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            a  = rand_op();
            b  = rand_op();
            m  = 23'($urandom);
            sh = 2'($urandom);
            send_beat(a, b, m, sh, model(a, b, m, sh));
        end
        in_valid = 1'b0;
        ready_mode = 1;
        for (int t = 0; t < 500 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        check("final_drain", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
